hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/rvx_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 51 +++++
 rtl/sb_pending.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 tb/tb_hazard_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : rvx_pkg                                                  |
// | Purpose   : Shared register-file constants and types for the hazard  |
// |             scoreboard (register count, outstanding-op limit,        |
// |             register address / vector / counter types).              |
// | Ports     : none (package)                                           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package rvx_pkg;

  localparam int NREG       = 32;
  localparam int SB_MAX_OUT = 4;
  localparam int CNT_W      = 3;

  typedef logic [4:0]       regaddr_t;
  typedef logic [NREG-1:0]  regvec_t;
  typedef logic [CNT_W-1:0] outcnt_t;

  // One-hot decode of a register address into a register-file-wide vector.
  function automatic regvec_t onehot(input regaddr_t addr);
    regvec_t v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : hazard_scoreboard_if                                     |
// | Purpose   : Groups the pipeline-side signals of the hazard scoreboard|
// | Ports     : master - pipeline side (drives decode/execute/writeback |
// |                      info, receives stall/flush/status)              |
// |             slave  - scoreboard side (the reverse)                   |
// |   Decode   : Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD,         |
// |              LongLatD, ValidD                                        |
// |   Execute  : RdE, ResultSrcE0, PCSrcE                                |
// |   Writeback: DoneW, RdDoneW                                          |
// |   Control  : StallF, StallD, FlushD, FlushE, OutCnt, SbErr           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface hazard_scoreboard_if;
  import rvx_pkg::*;

  regaddr_t Rs1D;
  regaddr_t Rs2D;
  logic     UsesRs1D;
  logic     UsesRs2D;
  regaddr_t RdD;
  logic     RegWriteD;
  logic     LongLatD;
  logic     ValidD;
  regaddr_t RdE;
  logic     ResultSrcE0;
  logic     PCSrcE;
  logic     DoneW;
  regaddr_t RdDoneW;
  logic     StallF;
  logic     StallD;
  logic     FlushD;
  logic     FlushE;
  outcnt_t  OutCnt;
  logic     SbErr;

  modport master (
    output Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, LongLatD, ValidD,
    output RdE, ResultSrcE0, PCSrcE, DoneW, RdDoneW,
    input  StallF, StallD, FlushD, FlushE, OutCnt, SbErr
  );

  modport slave (
    input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, LongLatD, ValidD,
    input  RdE, ResultSrcE0, PCSrcE, DoneW, RdDoneW,
    output StallF, StallD, FlushD, FlushE, OutCnt, SbErr
  );

endinterface
`default_nettype wire

// File: rtl/sb_pending.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : sb_pending                                               |
// | Purpose   : Pending-write vector P for long-latency results, its     |
// |             set/clear logic and the sticky protocol-error flag.      |
// | Ports     : clk, reset_n       clock, sync active-low reset           |
// |             set_en, set_rd     record a newly issued long op         |
// |             done, done_rd      long-latency completion               |
// |             pend_eff           P with this cycle's completion removed |
// |             done_ok            completion hit a pending register      |
// |             err                sticky: completion to a non-pending reg|
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module sb_pending
  import rvx_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     set_en,
  input  regaddr_t set_rd,
  input  logic     done,
  input  regaddr_t done_rd,
  output regvec_t  pend_eff,
  output logic     done_ok,
  output logic     err
);

  regvec_t pend;
  regvec_t clr_mask;
  regvec_t set_mask;
  regvec_t pend_nxt;

  // P[0] never gets set, so a completion to x0 is always an error.
  assign done_ok  = done & pend[done_rd];
  assign clr_mask = done ? onehot(done_rd) : '0;
  assign pend_eff = pend & ~clr_mask;
  assign set_mask = set_en ? onehot(set_rd) : '0;

  // Set wins over a same-cycle clear of the same register: the old op
  // retires while the new one takes ownership of the destination.
  always_comb begin
    pend_nxt    = pend_eff | set_mask;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (done && !done_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : hazard_scoreboard                                        |
// | Purpose   : Decode-stage hazard detection for an in-order pipeline   |
// |             with a variable-latency unit: RAW/WAW on pending long    |
// |             results, load-use, outstanding-op limit, branch flush.   |
// | Ports     : clk      rising-edge clock                               |
// |             reset_n  synchronous active-low reset                    |
// |             sb       hazard_scoreboard_if.slave (decode, execute,    |
// |                      writeback info in; stall/flush/OutCnt/SbErr out)|
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module hazard_scoreboard
  import rvx_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave sb
);

  regvec_t pend_eff;
  logic    done_ok;
  logic    sb_err;
  outcnt_t out_cnt;
  logic    long_wr;
  logic    raw_hz;
  logic    waw_hz;
  logic    lu_hz;
  logic    full_hz;
  logic    hz;
  logic    issue;

  assign long_wr = sb.ValidD & sb.LongLatD & sb.RegWriteD;

  assign raw_hz  = sb.ValidD & ((sb.UsesRs1D & pend_eff[sb.Rs1D]) |
                                (sb.UsesRs2D & pend_eff[sb.Rs2D]));

  assign waw_hz  = long_wr & (sb.RdD != '0) & pend_eff[sb.RdD];

  assign lu_hz   = sb.ValidD & sb.ResultSrcE0 & (sb.RdE != '0) &
                   ((sb.UsesRs1D & (sb.Rs1D == sb.RdE)) |
                    (sb.UsesRs2D & (sb.Rs2D == sb.RdE)));

  // A completion this cycle frees a slot for a same-cycle issue. Only a
  // completion that actually retires a pending op counts, so a bogus
  // completion can never let the count climb past the limit.
  assign full_hz = long_wr &
                   ((out_cnt - outcnt_t'(done_ok)) == outcnt_t'(SB_MAX_OUT));

  assign hz      = raw_hz | waw_hz | lu_hz | full_hz;

  assign issue   = long_wr & (sb.RdD != '0) & ~hz & ~sb.PCSrcE;

  assign sb.StallF = hz & ~sb.PCSrcE;
  assign sb.StallD = hz & ~sb.PCSrcE;
  assign sb.FlushD = sb.PCSrcE;
  assign sb.FlushE = hz | sb.PCSrcE;
  assign sb.OutCnt = out_cnt;
  assign sb.SbErr  = sb_err;

  sb_pending u_pending (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (issue),
    .set_rd   (sb.RdD),
    .done     (sb.DoneW),
    .done_rd  (sb.RdDoneW),
    .pend_eff (pend_eff),
    .done_ok  (done_ok),
    .err      (sb_err)
  );

  // Simultaneous issue and retire leaves the count unchanged; the bounds
  // checks keep it inside 0..SB_MAX_OUT even if upstream misbehaves.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_cnt <= '0;
    end else if (issue && !done_ok) begin
      if (out_cnt != outcnt_t'(SB_MAX_OUT)) begin
        out_cnt <= out_cnt + outcnt_t'(1);
      end
    end else if (!issue && done_ok) begin
      if (out_cnt != '0) begin
        out_cnt <= out_cnt - outcnt_t'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_hazard_scoreboard                                     |
// | Purpose   : Self-checking bench for hazard_scoreboard. Each step     |
// |             drives one decode/execute/writeback pattern, pushes the  |
// |             expected control/status word and compares it mid-cycle.  |
// | Ports     : none                                                     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_hazard_scoreboard;
  import rvx_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstn;
    logic       vd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ll;
    logic [4:0] rde;
    logic       ld;
    logic       pc;
    logic       dn;
    logic [4:0] rdd;
  } stim_t;

  // {StallF, StallD, FlushD, FlushE, OutCnt, SbErr}
  typedef struct packed {
    logic       stf;
    logic       std;
    logic       fld;
    logic       fle;
    logic [2:0] cnt;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic stim_t lop(input logic [4:0] rd);
    stim_t s;
    s    = idle();
    s.vd = 1'b1;
    s.rw = 1'b1;
    s.ll = 1'b1;
    s.rd = rd;
    return s;
  endfunction

  function automatic stim_t rdr(input logic [4:0] a, input logic ua,
                                input logic [4:0] b, input logic ub);
    stim_t s;
    s     = idle();
    s.vd  = 1'b1;
    s.rs1 = a;
    s.u1  = ua;
    s.rs2 = b;
    s.u2  = ub;
    return s;
  endfunction

  function automatic stim_t dn(input stim_t s0, input logic [4:0] r);
    stim_t s;
    s     = s0;
    s.dn  = 1'b1;
    s.rdd = r;
    return s;
  endfunction

  function automatic obs_t o(input logic a, input logic b, input logic c,
                             input logic d, input logic [2:0] n, input logic e);
    return {a, b, c, d, n, e};
  endfunction

  function automatic obs_t observe();
    return {sb_if.StallF, sb_if.StallD, sb_if.FlushD, sb_if.FlushE,
            sb_if.OutCnt, sb_if.SbErr};
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    reset_n           = s.rstn;
    sb_if.ValidD      = s.vd;
    sb_if.Rs1D        = s.rs1;
    sb_if.UsesRs1D    = s.u1;
    sb_if.Rs2D        = s.rs2;
    sb_if.UsesRs2D    = s.u2;
    sb_if.RdD         = s.rd;
    sb_if.RegWriteD   = s.rw;
    sb_if.LongLatD    = s.ll;
    sb_if.RdE         = s.rde;
    sb_if.ResultSrcE0 = s.ld;
    sb_if.PCSrcE      = s.pc;
    sb_if.DoneW       = s.dn;
    sb_if.RdDoneW     = s.rdd;
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    stim_t s;
    s = idle(); s.rstn = 1'b0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd0,0));
    s = rdr(5'd0,1'b0,5'd7,1'b1); s.rstn = 1'b0; s.ld = 1'b1; s.rde = 5'd7;
    st.push_back(s);                       ex.push_back(o(1,1,0,1,3'd0,0));
    s = idle(); s.rstn = 1'b0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_raw();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    st.push_back(lop(5'd5));                         ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(rdr(5'd5,1'b1,5'd0,1'b0));          ex.push_back(o(1,1,0,1,3'd1,0));
    st.push_back(rdr(5'd5,1'b1,5'd0,1'b0));          ex.push_back(o(1,1,0,1,3'd1,0));
    st.push_back(dn(rdr(5'd5,1'b1,5'd0,1'b0),5'd5)); ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(idle());                            ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL raw step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    stim_t s;
    s = rdr(5'd0,1'b0,5'd7,1'b1); s.ld = 1'b1; s.rde = 5'd7;
    st.push_back(s);                       ex.push_back(o(1,1,0,1,3'd0,0));
    s.u2 = 1'b0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd0,0));
    s = rdr(5'd7,1'b1,5'd0,1'b0); s.ld = 1'b1; s.rde = 5'd7;
    st.push_back(s);                       ex.push_back(o(1,1,0,1,3'd0,0));
    s.ld = 1'b0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd0,0));
    s = rdr(5'd0,1'b1,5'd0,1'b1); s.ld = 1'b1; s.rde = 5'd0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_full();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    st.push_back(lop(5'd1));               ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(lop(5'd2));               ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(lop(5'd3));               ex.push_back(o(0,0,0,0,3'd2,0));
    st.push_back(lop(5'd4));               ex.push_back(o(0,0,0,0,3'd3,0));
    st.push_back(lop(5'd6));               ex.push_back(o(1,1,0,1,3'd4,0));
    st.push_back(dn(lop(5'd6),5'd2));      ex.push_back(o(0,0,0,0,3'd4,0));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd4,0));
    st.push_back(lop(5'd7));               ex.push_back(o(1,1,0,1,3'd4,0));
    st.push_back(rdr(5'd1,1'b1,5'd6,1'b1)); ex.push_back(o(1,1,0,1,3'd4,0));
    st.push_back(rdr(5'd2,1'b1,5'd0,1'b0)); ex.push_back(o(0,0,0,0,3'd4,0));
    st.push_back(dn(idle(),5'd1));         ex.push_back(o(0,0,0,0,3'd4,0));
    st.push_back(dn(idle(),5'd3));         ex.push_back(o(0,0,0,0,3'd3,0));
    st.push_back(dn(idle(),5'd4));         ex.push_back(o(0,0,0,0,3'd2,0));
    st.push_back(dn(idle(),5'd6));         ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL full step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_same_reg();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    st.push_back(lop(5'd9));                ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(dn(lop(5'd9),5'd9));       ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(rdr(5'd9,1'b1,5'd0,1'b0)); ex.push_back(o(1,1,0,1,3'd1,0));
    st.push_back(lop(5'd9));                ex.push_back(o(1,1,0,1,3'd1,0));
    st.push_back(dn(idle(),5'd9));          ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(idle());                   ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL same_reg step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    stim_t s;
    st.push_back(lop(5'd10));              ex.push_back(o(0,0,0,0,3'd0,0));
    s = lop(5'd11); s.rs1 = 5'd10; s.u1 = 1'b1; s.pc = 1'b1;
    st.push_back(s);                       ex.push_back(o(0,0,1,1,3'd1,0));
    s = lop(5'd12); s.pc = 1'b1;
    st.push_back(s);                       ex.push_back(o(0,0,1,1,3'd1,0));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(dn(idle(),5'd10));        ex.push_back(o(0,0,0,0,3'd1,0));
    st.push_back(rdr(5'd11,1'b1,5'd12,1'b1)); ex.push_back(o(0,0,0,0,3'd0,0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_err_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, want;
    stim_t s;
    st.push_back(dn(idle(),5'd12));        ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd0,1));
    st.push_back(dn(idle(),5'd0));         ex.push_back(o(0,0,0,0,3'd0,1));
    st.push_back(lop(5'd13));              ex.push_back(o(0,0,0,0,3'd0,1));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd1,1));
    s = lop(5'd14); s.rstn = 1'b0;
    st.push_back(s);                       ex.push_back(o(0,0,0,0,3'd1,1));
    st.push_back(rdr(5'd13,1'b1,5'd14,1'b1)); ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(dn(idle(),5'd13));        ex.push_back(o(0,0,0,0,3'd0,0));
    st.push_back(idle());                  ex.push_back(o(0,0,0,0,3'd0,1));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL err_reset step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    sb_if.ValidD      = 1'b0;
    sb_if.Rs1D        = '0;
    sb_if.UsesRs1D    = 1'b0;
    sb_if.Rs2D        = '0;
    sb_if.UsesRs2D    = 1'b0;
    sb_if.RdD         = '0;
    sb_if.RegWriteD   = 1'b0;
    sb_if.LongLatD    = 1'b0;
    sb_if.RdE         = '0;
    sb_if.ResultSrcE0 = 1'b0;
    sb_if.PCSrcE      = 1'b0;
    sb_if.DoneW       = 1'b0;
    sb_if.RdDoneW     = '0;
    test_reset();
    test_raw();
    test_load_use();
    test_full();
    test_same_reg();
    test_branch();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
